// File: rtl/sa_act_skew_feeder.sv
// West-edge activation feeder: skews each accepted column diagonally across the
// array rows, then injects zero columns to drain the array and pulses done.

module sa_skew_lane #(
  parameter int DEPTH  = 1,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              adv_i,
  input  logic              clr_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] dout_o
);
  logic [DEPTH-1:0][DATA_W-1:0] sr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else if (clr_i) begin
      sr_q <= '0;
    end else if (adv_i) begin
      sr_q[0] <= din_i;
      for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
    end
  end

  assign dout_o = sr_q[DEPTH-1];
endmodule

module sa_act_skew_feeder #(
  parameter int ROWS         = 8,
  parameter int DATA_W       = 8,
  parameter int DRAIN_CYCLES = 24
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   stall,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic                   s_last,
  input  logic [ROWS*DATA_W-1:0] s_data,
  output logic [ROWS*DATA_W-1:0] pe_pixel,
  output logic                   pe_enable,
  output logic                   pe_reset_psum,
  output logic                   busy,
  output logic                   done
);
  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rst_psum_q, rst_psum_d;
  logic             done_q, done_d;
  logic             in_stream, in_drain, adv, last_adv;

  logic [ROWS-1:0][DATA_W-1:0] s_lanes, head, tail;

  assign in_stream = (state_q == S_STREAM);
  assign in_drain  = (state_q == S_DRAIN);
  // Bubbles and stalls freeze every lane together, so columns stay aligned by advance count.
  assign adv       = (in_stream & s_valid & ~stall) | (in_drain & ~stall);
  assign last_adv  = in_drain & adv & (cnt_q == CNT_W'(DRAIN_CYCLES - 1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rst_psum_d = 1'b0;
    done_d     = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          state_d    = S_STREAM;
          rst_psum_d = 1'b1;
        end
        S_STREAM: if (adv && s_last) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end
        S_DRAIN: if (adv) begin
          if (last_adv) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rst_psum_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rst_psum_q <= rst_psum_d;
      done_q     <= done_d;
    end
  end

  assign s_lanes = s_data;

  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    assign head[r] = in_stream ? s_lanes[r] : '0;
    sa_skew_lane #(.DEPTH(r + 1), .DATA_W(DATA_W)) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .adv_i  (adv),
      .clr_i  (abort),
      .din_i  (head[r]),
      .dout_o (tail[r])
    );
  end

  assign pe_pixel      = tail;
  assign s_ready       = in_stream & ~stall;
  assign pe_enable     = adv;
  assign pe_reset_psum = rst_psum_q;
  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
endmodule

// File: tb/tb_sa_act_skew_feeder.sv
// Directed bench for sa_act_skew_feeder (ROWS=4, DATA_W=8, DRAIN_CYCLES=6).
// Column n carries lane r = 0x11*(r+1) + n.

module tb_sa_act_skew_feeder;
  localparam int ROWS = 4, DW = 8, DC = 6;

  logic clk = 1'b0;
  logic rst_n, start, abort, stall, s_valid, s_ready, s_last;
  logic [ROWS*DW-1:0] s_data, pe_pixel;
  logic pe_enable, pe_reset_psum, busy, done;
  int nvec = 0, nmis = 0;

  always #5 clk = ~clk;

  sa_act_skew_feeder #(.ROWS(ROWS), .DATA_W(DW), .DRAIN_CYCLES(DC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .stall(stall),
    .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last), .s_data(s_data),
    .pe_pixel(pe_pixel), .pe_enable(pe_enable), .pe_reset_psum(pe_reset_psum),
    .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Expected lane r after k advances: column k-r-1 if it exists, else zero.
  function automatic logic [7:0] exp_pix(input int k, input int r, input int ncols);
    int j;
    j = k - r - 1;
    if (j >= 0 && j < ncols) return 8'(8'h11 * (r + 1) + j);
    return 8'h00;
  endfunction

  function automatic logic [ROWS*DW-1:0] col(input int n);
    logic [ROWS*DW-1:0] c;
    for (int r = 0; r < ROWS; r++) c[r*DW +: DW] = 8'(8'h11 * (r + 1) + n);
    return c;
  endfunction

  task automatic run_pass(input string nm, input int ncols, input bit gaps, input int dst_at);
    int k, sent, dadv, c, dst;
    bit drn, v, st, ea, fin;
    k = 0; sent = 0; dadv = 0; c = 0; dst = 0; drn = 0; fin = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({nm, "/psum_on"}, 32'(pe_reset_psum), 32'd1);
    chk({nm, "/busy"}, 32'(busy), 32'd1);
    while (!fin && c < 200) begin
      if (!drn) begin
        v  = gaps ? (c % 3 != 1) : 1'b1;
        st = gaps && c >= 4 && c < 7;
      end else begin
        v  = 1'b0;
        st = (dadv == dst_at) && (dst < 10);
        if (st) dst++;
      end
      s_valid = v && !drn;
      s_last  = (sent == ncols - 1);
      stall   = st;
      s_data  = v ? col(sent) : 'x;
      #1;
      ea = drn ? !st : (v && !st);
      chk({nm, "/en"}, 32'(pe_enable), 32'(ea));
      chk({nm, "/rdy"}, 32'(s_ready), 32'(!drn && !st));
      @(posedge clk); #1;
      if (ea) begin
        k++;
        if (drn) dadv++;
        else begin
          sent++;
          if (sent == ncols) drn = 1'b1;
        end
      end
      if (c == 0) chk({nm, "/psum_off"}, 32'(pe_reset_psum), 32'd0);
      for (int r = 0; r < ROWS; r++)
        chk($sformatf("%s/pix%0d@%0d", nm, r, k), 32'(pe_pixel[r*DW +: DW]), 32'(exp_pix(k, r, ncols)));
      if (drn && dadv == DC) begin
        chk({nm, "/done"}, 32'(done), 32'd1);
        chk({nm, "/idle"}, 32'(busy), 32'd0);
        fin = 1'b1;
      end else begin
        chk({nm, "/nodone"}, 32'(done), 32'd0);
      end
      c++;
    end
    chk({nm, "/timeout"}, 32'(fin), 32'd1);
    s_valid = 1'b0; stall = 1'b0; s_data = '0;
    @(posedge clk); #1;
    chk({nm, "/done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; stall = 1'b0;
    s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    #12;
    chk("rst/busy", 32'(busy), 32'd0);
    chk("rst/pix", pe_pixel, 32'd0);
    chk("rst/rdy", 32'(s_ready), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of a streaming cycle.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; s_valid = 1'b1; s_data = col(0);
    @(posedge clk); #1;
    chk("t1/pix0", 32'(pe_pixel[DW-1:0]), 32'h11);
    chk("t1/en", 32'(pe_enable), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t1/busy", 32'(busy), 32'd0);
    chk("t1/pix", pe_pixel, 32'd0);
    chk("t1/en0", 32'(pe_enable), 32'd0);
    chk("t1/rdy", 32'(s_ready), 32'd0);
    chk("t1/done", 32'(done), 32'd0);
    chk("t1/psum", 32'(pe_reset_psum), 32'd0);
    s_valid = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    run_pass("t2", 3, 1'b0, -1);
    run_pass("t3", 3, 1'b1, -1);
    run_pass("t4", 3, 1'b0, 2);

    // Abort together with start while streaming.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; s_valid = 1'b1; s_data = col(0);
    @(posedge clk); #1;
    s_data = col(1);
    @(posedge clk); #1;
    chk("t5/pix1", 32'(pe_pixel[DW +: DW]), 32'h22);
    abort = 1'b1; start = 1'b1; s_data = col(2);
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b0; s_valid = 1'b0;
    chk("t5/busy", 32'(busy), 32'd0);
    chk("t5/pix", pe_pixel, 32'd0);
    chk("t5/done", 32'(done), 32'd0);
    chk("t5/psum", 32'(pe_reset_psum), 32'd0);
    @(posedge clk); #1;
    chk("t5/busy2", 32'(busy), 32'd0);
    chk("t5/psum2", 32'(pe_reset_psum), 32'd0);
    chk("t5/done2", 32'(done), 32'd0);

    run_pass("t6", 1, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
